// File: rtl/sr_ff_monitor.sv
// Response checker for a clocked SR flop: predicts q from observed s/r and flags mismatches and s=r=1.
// One-cycle compare latency: q at an enabled edge is checked against the prediction held before that edge.
module sr_ff_monitor #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err,
    output logic             err_sticky,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt,
    output logic [CYC_W-1:0] cyc_cnt,
    output logic [CYC_W-1:0] first_err_cyc
);

    typedef enum logic {
        UNK = 1'b0,
        TRK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_exp_q;
    logic             w_exp_q_nxt;
    logic             w_mismatch;
    logic             w_illegal;
    logic             r_err;
    logic             r_illegal;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_ill_cnt;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [CYC_W-1:0] r_first_err_cyc;

    always_comb begin
        w_state_nxt = r_state;
        w_exp_q_nxt = r_exp_q;
        w_mismatch  = 1'b0;
        w_illegal   = 1'b0;
        if (en) begin
            // Compare always uses the pre-edge prediction, even while the command changes it.
            w_mismatch = (r_state == TRK) && (q != r_exp_q);
            case ({s, r})
                2'b10: begin
                    w_exp_q_nxt = 1'b1;
                    w_state_nxt = TRK;
                end
                2'b01: begin
                    w_exp_q_nxt = 1'b0;
                    w_state_nxt = TRK;
                end
                2'b11: begin
                    w_state_nxt = UNK;
                    w_illegal   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= UNK;
            r_exp_q         <= 1'b0;
            r_err           <= 1'b0;
            r_illegal       <= 1'b0;
            r_err_sticky    <= 1'b0;
            r_err_cnt       <= '0;
            r_ill_cnt       <= '0;
            r_cyc_cnt       <= '0;
            r_first_err_cyc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_q   <= w_exp_q_nxt;
            r_err     <= w_mismatch;
            r_illegal <= w_illegal;
            if (clr) begin
                r_err_sticky    <= 1'b0;
                r_err_cnt       <= '0;
                r_ill_cnt       <= '0;
                r_cyc_cnt       <= '0;
                r_first_err_cyc <= '0;
            end else if (en) begin
                r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                if (w_mismatch) begin
                    if (r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    if (!r_err_sticky) begin
                        r_err_sticky    <= 1'b1;
                        r_first_err_cyc <= r_cyc_cnt;
                    end
                end
                if (w_illegal && (r_ill_cnt != '1))
                    r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            end
        end
    end

    assign exp_q         = r_exp_q;
    assign exp_valid     = (r_state == TRK);
    assign err           = r_err;
    assign illegal       = r_illegal;
    assign err_sticky    = r_err_sticky;
    assign err_cnt       = r_err_cnt;
    assign ill_cnt       = r_ill_cnt;
    assign cyc_cnt       = r_cyc_cnt;
    assign first_err_cyc = r_first_err_cyc;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed-vector bench for sr_ff_monitor; inputs change just after each rising edge, outputs sampled there.
module tb_sr_ff_monitor;

    logic        clk = 1'b0;
    logic        rst, en, clr, s, r, q;
    logic        exp_q, exp_valid, err, err_sticky, illegal;
    logic [7:0]  err_cnt, ill_cnt;
    logic [15:0] cyc_cnt, first_err_cyc;
    int          checks = 0;
    int          failures = 0;

    sr_ff_monitor #(.CNT_W(8), .CYC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q),
        .exp_q(exp_q), .exp_valid(exp_valid), .err(err), .err_sticky(err_sticky),
        .illegal(illegal), .err_cnt(err_cnt), .ill_cnt(ill_cnt), .cyc_cnt(cyc_cnt),
        .first_err_cyc(first_err_cyc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_s, input logic i_r, input logic i_q);
        s = i_s; r = i_r; q = i_q;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b1; clr = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; clr = 1'b1; s = 1'b1; r = 1'b0; q = 1'b1;
        step();
        checks++; if ({exp_q, exp_valid, err, err_sticky, illegal} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {exp_q, exp_valid, err, err_sticky, illegal}); end
        checks++; if ({err_cnt, ill_cnt, cyc_cnt, first_err_cyc} !== 48'd0) begin failures++; $display("FAIL rst_counters got=%h exp=0", {err_cnt, ill_cnt, cyc_cnt, first_err_cyc}); end
        rst = 1'b1; clr = 1'b0;
    endtask

    task automatic test_commands();
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (exp_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL cmd00 valid=%b err=%b exp valid=0 err=0", exp_valid, err); end
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (exp_valid !== 1'b1 || exp_q !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL cmd01 valid=%b q=%b err=%b exp 1 0 0", exp_valid, exp_q, err); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (exp_q !== 1'b1 || err !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL cmd10 q=%b err=%b ill=%b exp 1 0 0", exp_q, err, illegal); end
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (illegal !== 1'b1 || exp_valid !== 1'b0 || err !== 1'b0 || exp_q !== 1'b1) begin failures++; $display("FAIL cmd11 ill=%b valid=%b err=%b q=%b exp 1 0 0 1", illegal, exp_valid, err, exp_q); end
        checks++; if (ill_cnt !== 8'd1 || cyc_cnt !== 16'd4) begin failures++; $display("FAIL cmd_counts ill_cnt=%0d cyc=%0d exp 1 4", ill_cnt, cyc_cnt); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (illegal !== 1'b0 || err !== 1'b0 || ill_cnt !== 8'd1) begin failures++; $display("FAIL cmd_pulse ill=%b err=%b ill_cnt=%0d exp 0 0 1", illegal, err, ill_cnt); end
    endtask

    task automatic test_mismatch();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1);
        checks++; if (cyc_cnt !== 16'd5 || err_cnt !== 8'd0) begin failures++; $display("FAIL mm_pre cyc=%0d err_cnt=%0d exp 5 0", cyc_cnt, err_cnt); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin failures++; $display("FAIL mm_first err=%b cnt=%0d sticky=%b exp 1 1 1", err, err_cnt, err_sticky); end
        checks++; if (first_err_cyc !== 16'd5) begin failures++; $display("FAIL mm_stamp got=%0d exp=5", first_err_cyc); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (err !== 1'b0 || err_sticky !== 1'b1) begin failures++; $display("FAIL mm_pulse err=%b sticky=%b exp 0 1", err, err_sticky); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (err !== 1'b1 || err_cnt !== 8'd2 || first_err_cyc !== 16'd5) begin failures++; $display("FAIL mm_second err=%b cnt=%0d stamp=%0d exp 1 2 5", err, err_cnt, first_err_cyc); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 254; i++) drive(1'b1, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd254) begin failures++; $display("FAIL sat_err_254 got=%0d exp=254", err_cnt); end
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd255 || err !== 1'b1) begin failures++; $display("FAIL sat_err got=%0d err=%b exp 255 1", err_cnt, err); end
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 1'b0);
        checks++; if (ill_cnt !== 8'd255 || illegal !== 1'b1) begin failures++; $display("FAIL sat_ill got=%0d ill=%b exp 255 1", ill_cnt, illegal); end
    endtask

    task automatic test_cyc_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++) drive(1'b0, 1'b0, 1'b0);
        checks++; if (cyc_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%0d exp=65535", cyc_cnt); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (cyc_cnt !== 16'd0) begin failures++; $display("FAIL wrap got=%0d exp=0", cyc_cnt); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (cyc_cnt !== 16'd3 || err_cnt !== 8'd1) begin failures++; $display("FAIL wrap_post cyc=%0d err_cnt=%0d exp 3 1", cyc_cnt, err_cnt); end
        en = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        checks++; if (cyc_cnt !== 16'd3 || err_cnt !== 8'd1 || ill_cnt !== 8'd0) begin failures++; $display("FAIL en_hold cyc=%0d err_cnt=%0d ill_cnt=%0d exp 3 1 0", cyc_cnt, err_cnt, ill_cnt); end
        checks++; if (err !== 1'b0 || illegal !== 1'b0 || exp_valid !== 1'b1 || exp_q !== 1'b1) begin failures++; $display("FAIL en_hold_st err=%b ill=%b valid=%b q=%b exp 0 0 1 1", err, illegal, exp_valid, exp_q); end
        en = 1'b1;
    endtask

    task automatic test_clr();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd1 || first_err_cyc !== 16'd1 || cyc_cnt !== 16'd2) begin failures++; $display("FAIL clr_pre cnt=%0d stamp=%0d cyc=%0d exp 1 1 2", err_cnt, first_err_cyc, cyc_cnt); end
        clr = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        clr = 1'b0;
        checks++; if (err !== 1'b1 || err_cnt !== 8'd0 || err_sticky !== 1'b0 || first_err_cyc !== 16'd0 || cyc_cnt !== 16'd0) begin failures++; $display("FAIL clr_mm err=%b cnt=%0d sticky=%b stamp=%0d cyc=%0d exp 1 0 0 0 0", err, err_cnt, err_sticky, first_err_cyc, cyc_cnt); end
        checks++; if (exp_q !== 1'b0 || exp_valid !== 1'b1) begin failures++; $display("FAIL clr_cmd q=%b valid=%b exp 0 1", exp_q, exp_valid); end
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (err_cnt !== 8'd1 || ill_cnt !== 8'd1 || cyc_cnt !== 16'd2) begin failures++; $display("FAIL clr_post cnt=%0d ill=%0d cyc=%0d exp 1 1 2", err_cnt, ill_cnt, cyc_cnt); end
        en = 1'b0; clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        en = 1'b1; clr = 1'b0;
        checks++; if (err_cnt !== 8'd0 || ill_cnt !== 8'd0 || cyc_cnt !== 16'd0 || err_sticky !== 1'b0) begin failures++; $display("FAIL clr_no_en cnt=%0d ill=%0d cyc=%0d sticky=%b exp 0 0 0 0", err_cnt, ill_cnt, cyc_cnt, err_sticky); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        checks++; if (err_cnt !== 8'd3 || exp_valid !== 1'b1) begin failures++; $display("FAIL rm_pre cnt=%0d valid=%b exp 3 1", err_cnt, exp_valid); end
        rst = 1'b0; clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b1; clr = 1'b0;
        checks++; if ({exp_q, exp_valid, err, err_sticky, illegal} !== 5'b0 || {err_cnt, ill_cnt, cyc_cnt, first_err_cyc} !== 48'd0) begin failures++; $display("FAIL rm_reset flags=%b cnt=%h exp 0", {exp_q, exp_valid, err, err_sticky, illegal}, {err_cnt, ill_cnt, cyc_cnt, first_err_cyc}); end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (err !== 1'b0 || exp_valid !== 1'b0 || err_cnt !== 8'd0 || cyc_cnt !== 16'd1) begin failures++; $display("FAIL rm_after err=%b valid=%b cnt=%0d cyc=%0d exp 0 0 0 1", err, exp_valid, err_cnt, cyc_cnt); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0;
        test_reset();
        test_commands();
        test_mismatch();
        test_saturation();
        test_cyc_wrap();
        test_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
